// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: icache read port, IF/ID write side and pipeline controls.
interface fetch_stage_if #(
  parameter int unsigned WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              id_stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] pc_next_out;
  logic              ifid_enable;
  logic              ifid_nop;
  logic              halted;

  modport master (
    output imemREN, imemaddr, instr_out, pc_next_out, ifid_enable, ifid_nop, halted,
    input  ihit, imemload, id_stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  imemREN, imemaddr, instr_out, pc_next_out, ifid_enable, ifid_nop, halted,
    output ihit, imemload, id_stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, holds icache requests until ihit, buffers one word
// across IF/ID stalls, and defers redirects/halt until any in-flight request completes.
module fetch_stage #(
  parameter int unsigned             WORD_W  = 32,
  parameter logic [WORD_W-1:0]       PC_INIT = '0
) (
  input  logic                CLK,
  input  logic                nRST,
  fetch_stage_if.master       bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [WORD_W-1:0] FOUR = WORD_W'(4);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_W-1:0] hold_pcn_q, hold_pcn_d;
  logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_halt_q, pend_halt_d;
  logic [WORD_W-1:0] pc_inc;

  assign pc_inc = pc_q + FOUR;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      hold_instr_q <= '0;
      hold_pcn_q   <= '0;
      pend_pc_q    <= '0;
      pend_halt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pcn_q   <= hold_pcn_d;
      pend_pc_q    <= pend_pc_d;
      pend_halt_q  <= pend_halt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pcn_d   = hold_pcn_q;
    pend_pc_d    = pend_pc_q;
    pend_halt_d  = pend_halt_q;
    case (state_q)
      FETCH: begin
        if (bus.halt) begin
          if (bus.ihit) begin
            state_d = HALTED;
          end else begin
            pend_halt_d = 1'b1;
            state_d     = SQUASH;
          end
        end else if (bus.redirect) begin
          if (bus.ihit) begin
            pc_d = bus.redirect_pc;
          end else begin
            pend_pc_d = bus.redirect_pc;
            state_d   = SQUASH;
          end
        end else if (bus.ihit) begin
          pc_d = pc_inc;
          if (bus.id_stall) begin
            hold_instr_d = bus.imemload;
            hold_pcn_d   = pc_inc;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end else if (!bus.id_stall) begin
          state_d = FETCH;
        end
      end
      SQUASH: begin
        // Requests arriving on the completing cycle still count, latest redirect wins.
        if (bus.ihit) begin
          if (pend_halt_q || bus.halt) begin
            state_d = HALTED;
          end else begin
            pc_d    = bus.redirect ? bus.redirect_pc : pend_pc_q;
            state_d = FETCH;
          end
        end else begin
          if (bus.halt)     pend_halt_d = 1'b1;
          if (bus.redirect) pend_pc_d   = bus.redirect_pc;
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.imemREN     = 1'b0;
    bus.imemaddr    = pc_q;
    bus.instr_out   = bus.imemload;
    bus.pc_next_out = pc_inc;
    bus.ifid_enable = 1'b0;
    bus.ifid_nop    = 1'b1;
    bus.halted      = 1'b0;
    case (state_q)
      FETCH: begin
        bus.imemREN = 1'b1;
        if (!(bus.halt || bus.redirect)) begin
          if (bus.ihit) begin
            bus.ifid_enable = !bus.id_stall;
            bus.ifid_nop    = 1'b0;
          end else begin
            bus.ifid_nop    = !bus.id_stall;
          end
        end
      end
      HOLD: begin
        bus.instr_out   = hold_instr_q;
        bus.pc_next_out = hold_pcn_q;
        if (!(bus.halt || bus.redirect)) begin
          bus.ifid_enable = !bus.id_stall;
          bus.ifid_nop    = 1'b0;
        end
      end
      SQUASH: begin
        bus.imemREN = 1'b1;
      end
      HALTED: begin
        bus.halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, misses, stall hold, redirects, halt and PC wrap.
module tb_fetch_stage;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;

  fetch_stage_if #(.WORD_W(32)) bus ();

  fetch_stage #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are observed 1ns later, well clear of posedge.
  task automatic cyc(input logic h, input logic [31:0] ld, input logic st,
                     input logic rd, input logic [31:0] rp, input logic hl);
    @(negedge CLK);
    bus.ihit        = h;
    bus.imemload    = ld;
    bus.id_stall    = st;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    bus.halt        = hl;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 5;
    if (bus.imemREN !== 1'b1) begin miscompares++; $display("FAIL rst_ren got %b exp 1", bus.imemREN); end
    if (bus.imemaddr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", bus.imemaddr); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL rst_en got %b exp 0", bus.ifid_enable); end
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL rst_nop got %b exp 1", bus.ifid_nop); end
    if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words[0] = 32'h1111_0000; words[1] = 32'h2222_0000; words[2] = 32'h3333_0000;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, words[i], 1'b0, 1'b0, 32'h0, 1'b0);
      vectors += 5;
      if (bus.imemaddr !== 32'(4*i)) begin miscompares++; $display("FAIL b2b_addr%0d got %h exp %h", i, bus.imemaddr, 4*i); end
      if (bus.ifid_enable !== 1'b1) begin miscompares++; $display("FAIL b2b_en%0d got %b exp 1", i, bus.ifid_enable); end
      if (bus.ifid_nop !== 1'b0) begin miscompares++; $display("FAIL b2b_nop%0d got %b exp 0", i, bus.ifid_nop); end
      if (bus.instr_out !== words[i]) begin miscompares++; $display("FAIL b2b_instr%0d got %h exp %h", i, bus.instr_out, words[i]); end
      if (bus.pc_next_out !== 32'(4*i+4)) begin miscompares++; $display("FAIL b2b_pcn%0d got %h exp %h", i, bus.pc_next_out, 4*i+4); end
    end
  endtask

  task automatic test_miss;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      vectors += 3;
      if (bus.imemaddr !== 32'hC) begin miscompares++; $display("FAIL miss_addr%0d got %h exp c", i, bus.imemaddr); end
      if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL miss_nop%0d got %b exp 1", i, bus.ifid_nop); end
      if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL miss_en%0d got %b exp 0", i, bus.ifid_enable); end
    end
    cyc(1'b1, 32'h4444_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'hC) begin miscompares++; $display("FAIL miss_hit_addr got %h exp c", bus.imemaddr); end
    if (bus.ifid_enable !== 1'b1) begin miscompares++; $display("FAIL miss_hit_en got %b exp 1", bus.ifid_enable); end
    if (bus.pc_next_out !== 32'h10) begin miscompares++; $display("FAIL miss_hit_pcn got %h exp 10", bus.pc_next_out); end
  endtask

  task automatic test_stall;
    cyc(1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'h10) begin miscompares++; $display("FAIL st_addr got %h exp 10", bus.imemaddr); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL st_en got %b exp 0", bus.ifid_enable); end
    if (bus.ifid_nop !== 1'b0) begin miscompares++; $display("FAIL st_nop got %b exp 0", bus.ifid_nop); end
    cyc(1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors += 5;
    if (bus.imemREN !== 1'b0) begin miscompares++; $display("FAIL hold_ren got %b exp 0", bus.imemREN); end
    if (bus.instr_out !== 32'hAAAA_5555) begin miscompares++; $display("FAIL hold_instr got %h exp aaaa5555", bus.instr_out); end
    if (bus.pc_next_out !== 32'h14) begin miscompares++; $display("FAIL hold_pcn got %h exp 14", bus.pc_next_out); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL hold_en got %b exp 0", bus.ifid_enable); end
    if (bus.ifid_nop !== 1'b0) begin miscompares++; $display("FAIL hold_nop got %b exp 0", bus.ifid_nop); end
    cyc(1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.ifid_enable !== 1'b1) begin miscompares++; $display("FAIL rel_en got %b exp 1", bus.ifid_enable); end
    if (bus.instr_out !== 32'hAAAA_5555) begin miscompares++; $display("FAIL rel_instr got %h exp aaaa5555", bus.instr_out); end
    if (bus.pc_next_out !== 32'h14) begin miscompares++; $display("FAIL rel_pcn got %h exp 14", bus.pc_next_out); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      vectors += 2;
      if (bus.imemREN !== 1'b1) begin miscompares++; $display("FAIL post_ren%0d got %b exp 1", i, bus.imemREN); end
      if (bus.imemaddr !== 32'(32'h14 + 4*i)) begin miscompares++; $display("FAIL post_addr%0d got %h exp %h", i, bus.imemaddr, 32'h14 + 4*i); end
    end
  endtask

  task automatic test_redirect_miss;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b0);
    vectors += 2;
    if (bus.imemaddr !== 32'h20) begin miscompares++; $display("FAIL rm_addr0 got %h exp 20", bus.imemaddr); end
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL rm_nop0 got %b exp 1", bus.ifid_nop); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'h20) begin miscompares++; $display("FAIL rm_addr1 got %h exp 20", bus.imemaddr); end
    if (bus.imemREN !== 1'b1) begin miscompares++; $display("FAIL rm_ren1 got %b exp 1", bus.imemREN); end
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL rm_nop1 got %b exp 1", bus.ifid_nop); end
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'h20) begin miscompares++; $display("FAIL rm_addr2 got %h exp 20", bus.imemaddr); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL rm_en2 got %b exp 0", bus.ifid_enable); end
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL rm_nop2 got %b exp 1", bus.ifid_nop); end
    cyc(1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'h400) begin miscompares++; $display("FAIL rm_addr3 got %h exp 400", bus.imemaddr); end
    if (bus.ifid_enable !== 1'b1) begin miscompares++; $display("FAIL rm_en3 got %b exp 1", bus.ifid_enable); end
    if (bus.pc_next_out !== 32'h404) begin miscompares++; $display("FAIL rm_pcn3 got %h exp 404", bus.pc_next_out); end
  endtask

  task automatic test_redirect_hit;
    cyc(1'b1, 32'h7777_0000, 1'b0, 1'b1, 32'h80, 1'b0);
    vectors += 2;
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL rh_nop got %b exp 1", bus.ifid_nop); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL rh_en got %b exp 0", bus.ifid_enable); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 1;
    if (bus.imemaddr !== 32'h80) begin miscompares++; $display("FAIL rh_addr got %h exp 80", bus.imemaddr); end
  endtask

  task automatic test_halt;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    vectors += 1;
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL h_nop0 got %b exp 1", bus.ifid_nop); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemREN !== 1'b1) begin miscompares++; $display("FAIL h_ren1 got %b exp 1", bus.imemREN); end
    if (bus.imemaddr !== 32'h80) begin miscompares++; $display("FAIL h_addr1 got %h exp 80", bus.imemaddr); end
    if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL h_halted1 got %b exp 0", bus.halted); end
    cyc(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 2;
    if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL h_halted2 got %b exp 0", bus.halted); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL h_en2 got %b exp 0", bus.ifid_enable); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 4;
    if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL h_halted3 got %b exp 1", bus.halted); end
    if (bus.imemREN !== 1'b0) begin miscompares++; $display("FAIL h_ren3 got %b exp 0", bus.imemREN); end
    if (bus.ifid_enable !== 1'b0) begin miscompares++; $display("FAIL h_en3 got %b exp 0", bus.ifid_enable); end
    if (bus.ifid_nop !== 1'b1) begin miscompares++; $display("FAIL h_nop3 got %b exp 1", bus.ifid_nop); end
    cyc(1'b1, 32'h9999_0000, 1'b0, 1'b1, 32'h500, 1'b0);
    cyc(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 2;
    if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL h_halted5 got %b exp 1", bus.halted); end
    if (bus.imemREN !== 1'b0) begin miscompares++; $display("FAIL h_ren5 got %b exp 0", bus.imemREN); end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    vectors += 3;
    if (bus.imemaddr !== 32'h0) begin miscompares++; $display("FAIL h_rst_addr got %h exp 0", bus.imemaddr); end
    if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL h_rst_halted got %b exp 0", bus.halted); end
    if (bus.imemREN !== 1'b1) begin miscompares++; $display("FAIL h_rst_ren got %b exp 1", bus.imemREN); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_wrap;
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 32'hABCD_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 3;
    if (bus.imemaddr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_addr got %h exp fffffffc", bus.imemaddr); end
    if (bus.pc_next_out !== 32'h0) begin miscompares++; $display("FAIL wr_pcn got %h exp 0", bus.pc_next_out); end
    if (bus.ifid_enable !== 1'b1) begin miscompares++; $display("FAIL wr_en got %b exp 1", bus.ifid_enable); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors += 1;
    if (bus.imemaddr !== 32'h0) begin miscompares++; $display("FAIL wr_addr_next got %h exp 0", bus.imemaddr); end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    nRST            = 1'b0;
    bus.ihit        = 1'b0;
    bus.imemload    = '0;
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    test_reset();
    test_back_to_back();
    test_miss();
    test_stall();
    test_redirect_miss();
    test_redirect_hit();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that drives the write side of the IF/ID pipeline latch.
- Owns the PC and issues level-held read requests to the instruction cache (imemREN/imemaddr, completed by ihit).
- Presents instruction and PC+4 to IF/ID and generates that latch's enable and nop (flush) controls.
- Absorbs downstream stalls with a one-entry hold buffer, and applies branch/jump redirects and halt without breaking an in-flight cache transaction.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
WORD_W, 32, instruction/address width; PC increment is fixed at 4.

Ports:
CLK  input  1  clock, rising edge.
nRST  input  1  reset, asynchronous, active-low.
imemREN  output  1  icache read request; held high until ihit.
imemaddr  output  WORD_W  icache read address; stable while imemREN high and no ihit.
ihit  input  1  icache completion; imemload valid this cycle.
imemload  input  WORD_W  returned instruction word.
id_stall  input  1  hazard unit: IF/ID must hold its contents.
redirect  input  1  branch/jump taken; one-cycle pulse.
redirect_pc  input  WORD_W  target PC, valid with redirect.
halt  input  1  stop fetching; sticky once accepted.
instr_out  output  WORD_W  instruction to IF/ID instr_in.
pc_next_out  output  WORD_W  PC+4 of instr_out to IF/ID pc_next_in.
ifid_enable  output  1  IF/ID load enable.
ifid_nop  output  1  IF/ID flush (insert bubble).
halted  output  1  high in HALTED state.

Behaviour:
- Registers: pc, state, hold_instr, hold_pcn, pend_pc, pend_halt. All outputs are combinational from registers and inputs.
- Reset (async, nRST low):
  - pc=PC_INIT, state=FETCH, hold_instr=0, hold_pcn=0, pend_pc=0, pend_halt=0.
  - Resulting outputs: imemREN=1, imemaddr=PC_INIT, ifid_enable=0, ifid_nop=1, halted=0.
  - Reset mid-transaction abandons the request; the cache is reset by the same nRST.
- Priority each cycle: halt > redirect > ihit/stall handling.
- FETCH:
  - Outputs: imemREN=1, imemaddr=pc, instr_out=imemload, pc_next_out=pc+4.
  - ihit & !id_stall: ifid_enable=1, ifid_nop=0, pc<=pc+4, stay FETCH. Back-to-back hits give 1 instruction/cycle.
  - ihit & id_stall: ifid_enable=0, ifid_nop=0; hold_instr<=imemload, hold_pcn<=pc+4, pc<=pc+4, go HOLD.
  - !ihit & !id_stall: ifid_enable=0, ifid_nop=1 (bubble).
  - !ihit & id_stall: ifid_enable=0, ifid_nop=0.
  - redirect & ihit: returned word discarded; pc<=redirect_pc; ifid_nop=1; stay FETCH.
  - redirect & !ihit: ifid_nop=1; pend_pc<=redirect_pc; go SQUASH. The address is not changed mid-transaction.
  - halt & ihit: discard word; ifid_nop=1; go HALTED.
  - halt & !ihit: pend_halt<=1; ifid_nop=1; go SQUASH.
- HOLD:
  - Outputs: imemREN=0, instr_out=hold_instr, pc_next_out=hold_pcn.
  - id_stall=1: ifid_enable=0, ifid_nop=0.
  - id_stall=0: ifid_enable=1, ifid_nop=0, go FETCH. The next fetch begins the following cycle at the already-incremented pc.
  - redirect: buffer discarded; pc<=redirect_pc; ifid_nop=1; go FETCH. There is no outstanding request, so no SQUASH.
  - halt: ifid_nop=1; go HALTED.
- SQUASH:
  - Outputs: imemREN=1, imemaddr=pc (old address held), ifid_enable=0, ifid_nop=1.
  - On ihit: data discarded. If pend_halt, go HALTED; else pc<=pend_pc, go FETCH.
  - A further redirect while in SQUASH overwrites pend_pc (latest wins).
  - halt while in SQUASH sets pend_halt.
- HALTED:
  - Outputs: imemREN=0, ifid_enable=0, ifid_nop=1, halted=1.
  - All inputs ignored until reset.
- Arithmetic: pc+4 is modulo 2^WORD_W (32'hFFFF_FFFC + 4 = 0). No alignment check is made on redirect_pc.
- Invariant: ifid_enable and ifid_nop are never both 1.

Test Plan:
- Reset, ihit tied 1, no stall: instr 0x1111_0000/0x2222_0000/0x3333_0000 return for pc 0x0/0x4/0x8 -> ifid_enable=1 three consecutive cycles; pc_next_out 0x4, 0x8, 0xC; imemaddr 0x0, 0x4, 0x8.
- ihit delayed 3 cycles per access, no stall -> ifid_nop=1 during the 2 miss cycles, ifid_enable=1 on the hit cycle; imemaddr stable for all 3 cycles.
- Hit at pc 0x10 with id_stall high 2 cycles -> HOLD; instr_out=hold word and pc_next_out=0x14 steady; imemREN=0. Stall drop -> ifid_enable=1 one cycle, next imemaddr=0x14.
- Redirect to 0x400 while pc 0x20 is mid-miss (ihit 2 cycles later) -> ifid_nop=1 throughout; imemaddr stays 0x20 until ihit; then imemaddr=0x400. Word from 0x20 never loaded.
- Redirect to 0x80 and ihit in the same cycle -> ifid_nop=1, ifid_enable=0; next imemaddr=0x80.
- Halt mid-miss, then ihit -> halted=1, imemREN=0 from the cycle after ihit; later redirect ignored. nRST pulse -> imemaddr=PC_INIT, halted=0.
